// File: rtl/img_pkg.sv
// ---------------------------------------------------------------------------
// img_pkg
// Shared types and helpers for the image pipeline (frame loader, downscaler,
// writeback).
//   pixel_t       : one 8-bit greyscale pixel
//   load_state_e  : frame loader FSM states
//   DEF_SRC_H/W   : default source image geometry
//   cnt_bits()    : counter width able to index 0..n-1 (at least 1 bit)
//   addr_bits()   : linear pixel address width for an h x w image
// ---------------------------------------------------------------------------
package img_pkg;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } load_state_e;

  localparam int DEF_SRC_H = 32;
  localparam int DEF_SRC_W = 32;

  function automatic int cnt_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int addr_bits(input int h, input int w);
    return cnt_bits(h * w);
  endfunction

endpackage

// File: rtl/img_raster_counter.sv
// ---------------------------------------------------------------------------
// img_raster_counter
// Raster-order position counter: tracks row, column and the linear index
// row*W+col as three separate registers so no divider or multiplier is needed.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears all counters)
//   clr_i    : synchronous clear back to pixel 0
//   inc_i    : advance to the next pixel (ignored on the last pixel)
//   row_o    : current row
//   col_o    : current column
//   idx_o    : current linear index
//   last_o   : current position is the last pixel (H-1, W-1)
// ---------------------------------------------------------------------------
module img_raster_counter
  import img_pkg::*;
#(
  parameter int H        = DEF_SRC_H,
  parameter int W        = DEF_SRC_W,
  parameter int ROW_BITS = cnt_bits(H),
  parameter int COL_BITS = cnt_bits(W),
  parameter int IDX_BITS = addr_bits(H, W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [ROW_BITS-1:0] row_o,
  output logic [COL_BITS-1:0] col_o,
  output logic [IDX_BITS-1:0] idx_o,
  output logic                last_o
);

  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(H - 1);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(W - 1);

  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic                last;

  assign last = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // Increment saturates at the last pixel so the index can never wrap.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    idx_d = idx_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
      idx_d = '0;
    end else if (inc_i && !last) begin
      idx_d = idx_q + 1'b1;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
      idx_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      idx_q <= idx_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign idx_o  = idx_q;
  assign last_o = last;

endmodule

// File: rtl/frame_loader_seq.sv
// ---------------------------------------------------------------------------
// frame_loader_seq
// Reads an SRC_H x SRC_W image from a sequential-port memory, one raster-order
// pixel per rd_req/rd_valid handshake, into a 2D frame array for the
// downscaler. Signals done (level) and a one-cycle ds_start on success; a
// per-read watchdog aborts with error when memory never answers.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin a load (accepted only in IDLE or DONE)
//   rd_req    : one-cycle read request (REQ state)
//   rd_addr   : read address = current linear pixel index
//   rd_valid  : read data valid (sampled only in WAIT)
//   rd_data   : read data
//   frame     : loaded image, frame[row][col]
//   busy      : load in progress (REQ or WAIT)
//   done      : DONE state, held until the next accepted start
//   error     : watchdog expired on the last load
//   ds_start  : one-cycle pulse on the first DONE cycle of a successful load
// ---------------------------------------------------------------------------
module frame_loader_seq
  import img_pkg::*;
#(
  parameter int SRC_H       = DEF_SRC_H,
  parameter int SRC_W       = DEF_SRC_W,
  parameter int ADDR_BITS   = addr_bits(SRC_H, SRC_W),
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 rd_req,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic                 rd_valid,
  input  pixel_t               rd_data,
  output pixel_t               frame [SRC_H][SRC_W],
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 ds_start
);

  localparam int ROW_BITS = cnt_bits(SRC_H);
  localparam int COL_BITS = cnt_bits(SRC_W);
  localparam int WD_BITS  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_BITS-1:0] WD_LIMIT = WD_BITS'(TIMEOUT_CYC);

  load_state_e         state_q, state_d;
  logic [WD_BITS-1:0]  wd_q, wd_d, wd_inc;
  logic                error_q, error_d;
  logic                ds_start_q, ds_start_d;
  logic                cnt_clr, cnt_inc, pix_we;

  logic [ROW_BITS-1:0]  row;
  logic [COL_BITS-1:0]  col;
  logic [ADDR_BITS-1:0] idx;
  logic                 last_pix;

  img_raster_counter #(
    .H        (SRC_H),
    .W        (SRC_W),
    .ROW_BITS (ROW_BITS),
    .COL_BITS (COL_BITS),
    .IDX_BITS (ADDR_BITS)
  ) u_pos (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .row_o  (row),
    .col_o  (col),
    .idx_o  (idx),
    .last_o (last_pix)
  );

  assign wd_inc = wd_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    wd_d       = wd_q;
    error_d    = error_q;
    ds_start_d = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    pix_we     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_REQ;
          cnt_clr = 1'b1;
          wd_d    = '0;
          error_d = 1'b0;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rd_valid) begin
          pix_we = 1'b1;
          wd_d   = '0;
          if (last_pix) begin
            state_d    = ST_DONE;
            ds_start_d = 1'b1;  // lands in the first DONE cycle only
          end else begin
            cnt_inc = 1'b1;
            state_d = ST_REQ;
          end
        end else begin
          wd_d = wd_inc;
          // Index is not advanced, so rd_addr keeps the failed address.
          if (wd_inc == WD_LIMIT) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wd_q       <= '0;
      error_q    <= 1'b0;
      ds_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      error_q    <= error_d;
      ds_start_q <= ds_start_d;
    end
  end

  // Frame storage: one register row per image row, no reset on the data.
  generate
    for (genvar gi = 0; gi < SRC_H; gi++) begin : g_row
      pixel_t row_q [SRC_W];

      always_ff @(posedge clk) begin
        if (pix_we && (row == ROW_BITS'(gi))) begin
          row_q[col] <= rd_data;
        end
      end

      for (genvar gj = 0; gj < SRC_W; gj++) begin : g_col
        assign frame[gi][gj] = row_q[gj];
      end
    end
  endgenerate

  assign rd_req   = (state_q == ST_REQ);
  assign rd_addr  = idx;
  assign busy     = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign done     = (state_q == ST_DONE);
  assign error    = error_q;
  assign ds_start = ds_start_q;

endmodule

// File: tb/tb_frame_loader_seq.sv
// ---------------------------------------------------------------------------
// tb_frame_loader_seq
// Self-checking bench for frame_loader_seq: behavioural memory responder with
// configurable latency, transaction-level address model, per-cycle protocol
// checks and end-of-load frame/latency checks.
// ---------------------------------------------------------------------------
module tb_frame_loader_seq;
  import img_pkg::*;

  localparam int H  = 32;
  localparam int W  = 32;
  localparam int N  = H * W;
  localparam int AB = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          rd_req;
  logic [AB-1:0] rd_addr;
  logic          rd_valid;
  pixel_t        rd_data;
  pixel_t        frame [H][W];
  logic          busy, done, error, ds_start;

  frame_loader_seq #(
    .SRC_H       (H),
    .SRC_W       (W),
    .ADDR_BITS   (AB),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .frame    (frame),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .ds_start (ds_start)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  pixel_t mem [N];
  int     latency   = 1;
  bit     mem_en    = 1'b1;
  bit     spur      = 1'b0;
  pixel_t spur_data = 8'hEE;
  bit     chk_en    = 1'b0;
  bit     acc_start = 1'b0;

  // responder state
  int cd          = 0;
  int pend_addr   = 0;
  int pend_gen    = -1;
  int resp_gen    = -1;
  bit resp_valid  = 1'b0;
  bit pend_at_req = 1'b0;

  // model: next address the loader must request, and current load generation
  int exp_addr = 0;
  int load_gen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++)
        mem[i*W+j] = pixel_t'((i*4 + j*2) & 8'hFF);
  endtask

  task automatic check_frame(input string name);
    int nbad;
    nbad = 0;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++)
        if (frame[i][j] !== mem[i*W+j]) nbad++;
    chk({name, "_frame_mismatches"}, nbad, 0);
  endtask

  // Memory: answers each request exactly `latency` cycles after the rd_req
  // cycle; spur injects unsolicited rd_valid pulses.
  initial begin
    rd_valid = 1'b0;
    rd_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      resp_valid = 1'b0;
      rd_data    = spur_data;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          resp_valid = 1'b1;
          resp_gen   = pend_gen;
          rd_data    = mem[pend_addr];
        end
      end
      pend_at_req = rd_req && (cd > 0 || resp_valid);
      if (rd_req && mem_en) begin
        cd        = latency;
        pend_addr = int'(rd_addr);
        pend_gen  = load_gen;
      end
      rd_valid = resp_valid | spur;
    end
  end

  // Address model: a new load or reset restarts at 0; each answered read of
  // the current load moves to the next pixel.
  always @(posedge clk) begin
    if (rst || (start && acc_start)) begin
      exp_addr <= 0;
      load_gen <= load_gen + 1;
    end else if (resp_valid && resp_gen == load_gen && exp_addr != N-1) begin
      exp_addr <= exp_addr + 1;
    end
  end

  // Per-cycle protocol compare.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (chk_en) begin
        if (rd_req) begin
          chk("rd_addr_seq", rd_addr, exp_addr);
          chk("req_while_outstanding", pend_at_req, 0);
        end
        chk("busy_done_exclusive", busy & done, 0);
        if (ds_start) chk("ds_start_only_ok_done", done & ~error, 1);
      end
    end
  end

  task automatic run_load(input string name, input int lat, input int exp_cyc,
                          input bit exp_err, input bit spur_start);
    int cyc;
    int ds_cnt;
    latency   = lat;
    start     = 1'b1;
    acc_start = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    start     = 1'b0;
    acc_start = 1'b0;
    chk({name, "_busy_after_start"}, busy, 1);
    chk({name, "_done_clear"}, done, 0);
    chk({name, "_error_clear"}, error, 0);
    ds_cnt = int'(ds_start);
    while (!done && cyc < 20000) begin
      start = spur_start && busy && !rd_req && ($urandom_range(0, 7) == 0);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
      if (ds_start) ds_cnt++;
    end
    chk({name, "_start_to_done"}, cyc, exp_cyc);
    chk({name, "_error"}, error, exp_err);
    chk({name, "_ds_start_count"}, ds_cnt, exp_err ? 0 : 1);
    $display("load %s: lat=%0d cycles=%0d ds_start=%0d error=%0d", name, lat, cyc, ds_cnt, error);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int w;
    int lat;
    rst   = 1'b1;
    start = 1'b0;
    fill_ramp();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_ds_start", ds_start, 0);
    chk("reset_rd_req", rd_req, 0);
    chk("reset_rd_addr", rd_addr, 0);
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // ramp, L=1
    run_load("ramp_l1", 1, 2049, 1'b0, 1'b0);
    check_frame("ramp_l1");
    chk("pin_f0_1", frame[0][1], 8'd2);
    chk("pin_f1_0", frame[1][0], 8'd4);
    chk("pin_f2_3", frame[2][3], 8'd14);
    chk("pin_f31_31", frame[31][31], 8'd186);
    @(negedge clk);
    chk("ramp_ds_start_one_cycle", ds_start, 0);
    chk("ramp_done_level", done, 1);

    // unsolicited rd_valid while in DONE
    spur = 1'b1;
    repeat (4) @(negedge clk);
    spur = 1'b0;
    repeat (2) @(negedge clk);
    chk("done_spur_still_done", done, 1);
    chk("done_spur_not_busy", busy, 0);
    check_frame("done_spur");

    // slow memory
    run_load("slow_l3", 3, 4097, 1'b0, 1'b0);
    check_frame("slow_l3");

    // unsolicited rd_valid in IDLE, then a load with spurious starts in WAIT
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    spur = 1'b1;
    repeat (3) @(negedge clk);
    spur = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_spur_not_busy", busy, 0);
    chk("idle_spur_not_done", done, 0);
    run_load("spur_l2", 2, 3073, 1'b0, 1'b1);
    check_frame("spur_l2");

    // timeout: memory never answers
    mem_en = 1'b0;
    run_load("timeout", 1, 66, 1'b1, 1'b0);
    chk("timeout_rd_addr", rd_addr, 0);
    chk("timeout_done", done, 1);
    @(negedge clk);
    chk("timeout_error_held", error, 1);
    chk("timeout_no_ds_start", ds_start, 0);
    mem_en = 1'b1;

    // reset in the middle of a load
    latency   = 1;
    start     = 1'b1;
    acc_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    acc_start = 1'b0;
    w = 0;
    while (!(rd_req && rd_addr == 10'd100) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("midload_reached_idx100", (w < 1000), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_rd_req", rd_req, 0);
    chk("midreset_rd_addr", rd_addr, 0);
    chk("midreset_error", error, 0);
    rst = 1'b0;
    @(negedge clk);
    run_load("after_reset", 1, 2049, 1'b0, 1'b0);
    check_frame("after_reset");

    // random contents, random latency, spurious starts
    for (int i = 0; i < N; i++) mem[i] = pixel_t'($urandom_range(0, 255));
    lat = int'($urandom_range(1, 4));
    run_load("random", lat, N*(lat+1)+1, 1'b0, 1'b1);
    check_frame("random");

    // back-to-back: restart on the first DONE cycle with new memory contents
    fill_ramp();
    run_load("b2b_first", 1, 2049, 1'b0, 1'b0);
    check_frame("b2b_first");
    for (int i = 0; i < N; i++) mem[i] = 8'hA5;
    run_load("b2b_second", 1, 2049, 1'b0, 1'b0);
    check_frame("b2b_second");
    chk("pin_b2b_f5_7", frame[5][7], 8'hA5);

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
